onebit_ctrl: RTL and testbench

Cycle-accurate sequencer for the single-bit SRAM cell and its sense amplifier. It turns a valid/ready read or write request into the bitline-precharge, wordline, write-driver and sense-enable waveforms (preb, wl, wlb, w_en, write_bit, sae). It then returns a registered response. Reads are differential: the cell is sensed once through wl (Q side) and once through wlb (QB side), and the two samples are cross-checked. The block sits between the bit-array test/BIST logic and the onebit cell macro.

---
 rtl/onebit_ctrl_pkg.sv | 40 ++++
 rtl/onebit_ctrl_timer.sv | 27 ++
 rtl/onebit_ctrl.sv | 138 +++++++++++++
 tb/tb_onebit_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/onebit_ctrl_pkg.sv
// Shared types and helpers for the single-bit SRAM cell sequencer.
// The state-to-control mapping is used by both the controller and its bench.
package onebit_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_A,
        WRITE,
        RD_Q,
        PRE_B,
        RD_QB,
        PRE_C,
        RESP
    } state_t;

    localparam int PRE_CYC_DEF = 2;
    localparam int ACC_CYC_DEF = 2;

    typedef struct packed {
        logic preb;
        logic wl;
        logic wlb;
        logic w_en;
        logic sae;
    } ctrl_t;

    // sae here marks a sense phase; the controller narrows it to the last cycle
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            WRITE:   c = ctrl_t'(5'b11110);
            RD_Q:    c = ctrl_t'(5'b11001);
            RD_QB:   c = ctrl_t'(5'b10101);
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/onebit_ctrl_timer.sv
// Shared 4-bit phase down-counter: loaded with len-1, done at zero.
// last flags the cycle just before done so callers can register edge-aligned pulses.
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] len,
    output logic       done,
    output logic       last
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= len - 4'd1;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd0);
    assign last = (cnt == 4'd1);

endmodule

// File: rtl/onebit_ctrl.sv
// Sequencer turning valid/ready requests into precharge, wordline, write and
// sense waveforms for the onebit cell, with a differential read cross-check.
module onebit_ctrl
    import onebit_ctrl_pkg::*;
#(
    parameter int PRE_CYC = PRE_CYC_DEF,
    parameter int ACC_CYC = ACC_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_we,
    input  logic req_wdata,
    output logic rsp_valid,
    input  logic rsp_ready,
    output logic rsp_rdata,
    output logic rsp_err,
    input  logic sa_out,
    output logic preb,
    output logic wl,
    output logic wlb,
    output logic w_en,
    output logic write_bit,
    output logic sae,
    output logic busy
);

    localparam logic [3:0] PL = 4'(PRE_CYC);
    localparam logic [3:0] AL = 4'(ACC_CYC);

    state_t     state;
    state_t     nxt;
    logic       load;
    logic [3:0] len;
    logic       done;
    logic       last;
    logic       accept;
    logic       we_r;
    logic       wd_r;
    logic       q_s;
    logic       qb_s;
    ctrl_t      c_n;
    logic       sae_n;

    phase_timer u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .len  (len),
        .done (done),
        .last (last)
    );

    assign accept = req_valid & req_ready;

    always_comb begin
        nxt  = state;
        load = 1'b0;
        len  = PL;
        unique case (state)
            IDLE: if (accept) begin
                nxt  = PRE_A;
                load = 1'b1;
            end
            PRE_A: if (done) begin
                nxt  = we_r ? WRITE : RD_Q;
                load = 1'b1;
                len  = AL;
            end
            WRITE: if (done) begin
                nxt  = PRE_C;
                load = 1'b1;
            end
            RD_Q: if (done) begin
                nxt  = PRE_B;
                load = 1'b1;
            end
            PRE_B: if (done) begin
                nxt  = RD_QB;
                load = 1'b1;
                len  = AL;
            end
            RD_QB: if (done) begin
                nxt  = PRE_C;
                load = 1'b1;
            end
            PRE_C: if (done) nxt = RESP;
            RESP:  if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    assign c_n   = ctrl_of(nxt);
    assign sae_n = c_n.sae & (load ? (AL == 4'd1) : last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_r      <= 1'b0;
            wd_r      <= 1'b0;
            q_s       <= 1'b0;
            qb_s      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 1'b0;
            rsp_err   <= 1'b0;
            preb      <= 1'b0;
            wl        <= 1'b0;
            wlb       <= 1'b0;
            w_en      <= 1'b0;
            write_bit <= 1'b0;
            sae       <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                we_r <= req_we;
                wd_r <= req_wdata;
            end
            if (state == RD_Q && done) q_s <= sa_out;
            if (state == RD_QB && done) qb_s <= sa_out;
            req_ready <= (nxt == IDLE);
            busy      <= (nxt != IDLE);
            rsp_valid <= (nxt == RESP);
            rsp_rdata <= (nxt == RESP) & ~we_r & q_s;
            rsp_err   <= (nxt == RESP) & ~we_r & (q_s == qb_s);
            preb      <= c_n.preb;
            wl        <= c_n.wl;
            wlb       <= c_n.wlb;
            w_en      <= c_n.w_en;
            write_bit <= c_n.w_en & wd_r;
            sae       <= sae_n;
        end
    end

endmodule

// File: tb/tb_onebit_ctrl.sv
// Bench for onebit_ctrl: default-timing instance plus a PRE=1/ACC=1 instance.
// Responses are scored against a queue filled when each request is accepted.
module tb_onebit_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n[2];
    logic req_valid[2];
    logic req_we[2];
    logic req_wdata[2];
    logic rsp_ready[2];
    logic sa_out[2];
    logic req_ready[2];
    logic rsp_valid[2];
    logic rsp_rdata[2];
    logic rsp_err[2];
    logic preb[2];
    logic wl[2];
    logic wlb[2];
    logic w_en[2];
    logic write_bit[2];
    logic sae[2];
    logic busy[2];

    int vec = 0;
    int errs = 0;
    logic [1:0] sb[$];

    onebit_ctrl dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .sa_out(sa_out[0]), .preb(preb[0]), .wl(wl[0]), .wlb(wlb[0]),
        .w_en(w_en[0]), .write_bit(write_bit[0]), .sae(sae[0]),
        .busy(busy[0])
    );

    onebit_ctrl #(.PRE_CYC(1), .ACC_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .sa_out(sa_out[1]), .preb(preb[1]), .wl(wl[1]), .wlb(wlb[1]),
        .w_en(w_en[1]), .write_bit(write_bit[1]), .sae(sae[1]),
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        vec++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] outs(int d);
        return {req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d],
                preb[d], wl[d], wlb[d], w_en[d], write_bit[d], sae[d],
                busy[d]};
    endfunction

    function automatic logic [5:0] ctl(int d);
        return {preb[d], wl[d], wlb[d], w_en[d], write_bit[d], sae[d]};
    endfunction

    // {preb, wl, wlb, w_en, write_bit, sae} for cycle k after the accept edge
    function automatic logic [5:0] exp_ctrl(int p, int a, logic we,
                                            logic wd, int k);
        if (we)
            return (k > p && k <= p + a) ? {4'b1111, wd, 1'b0} : 6'b0;
        if (k > p && k <= p + a)
            return {5'b11000, k == p + a};
        if (k > 2 * p + a && k <= 2 * p + 2 * a)
            return {5'b10100, k == 2 * p + 2 * a};
        return 6'b0;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic ok;
            ok = (!(wl[d] | wlb[d]) || preb[d])
              && (!w_en[d] || (wl[d] & wlb[d]))
              && !(sae[d] & w_en[d])
              && (w_en[d] || !write_bit[d]);
            chk("invariant", 16'(ok), 16'd1);
        end
    end

    task automatic txn(input int d, input logic we, input logic wd,
                       input logic qv, input logic qbv, input int stall,
                       input logic hold);
        int p;
        int a;
        int lat;
        int n;
        logic early;
        logic [1:0] e;
        p = (d == 1) ? 1 : 2;
        a = (d == 1) ? 1 : 2;
        lat = we ? 2 * p + a : 3 * p + 2 * a;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d] = we;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk("accept_timeout", 16'(req_ready[d]), 16'd1);
            req_valid[d] = 1'b0;
            return;
        end
        sb.push_back(we ? 2'b00 : {qv, qv == qbv});
        @(posedge clk);
        early = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            #1;
            req_valid[d] = hold;
            sa_out[d] = (k == p + a) ? qv :
                        (k == 2 * p + 2 * a) ? qbv : 1'($urandom);
            @(negedge clk);
            chk("ctrl", 16'(ctl(d)), 16'(exp_ctrl(p, a, we, wd, k)));
            if (k <= lat) begin
                early |= rsp_valid[d];
                @(posedge clk);
            end
        end
        chk("no_early_rsp", 16'(early), 16'd0);
        chk("rsp_valid", 16'(rsp_valid[d]), 16'd1);
        e = sb.pop_front();
        chk("rsp_data", 16'({rsp_rdata[d], rsp_err[d]}), 16'(e));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("stall_hold",
                16'({busy[d], req_ready[d], rsp_valid[d], rsp_rdata[d],
                     rsp_err[d]}),
                16'({3'b101, e}));
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        @(negedge clk);
        chk("idle_after",
            16'({rsp_valid[d], busy[d], req_ready[d]}), 16'b001);
    endtask

    initial begin
        logic flag;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_wdata[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            sa_out[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outs0", 16'(outs(0)), 16'd0);
        chk("reset_outs1", 16'(outs(1)), 16'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("first_ready0", 16'(outs(0)), 16'(11'b100_0000_0000));
        chk("first_ready1", 16'(outs(1)), 16'(11'b100_0000_0000));

        txn(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        txn(0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b1);
        txn(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        txn(0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);

        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        chk("rst_pre_ready", 16'(req_ready[0]), 16'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("in_rd_q", 16'({preb[0], wl[0], busy[0]}), 16'b111);
        rst_n[0] = 1'b0;
        #1;
        chk("rst_async", 16'(outs(0)), 16'd0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("rst_release", 16'(outs(0)), 16'(11'b100_0000_0000));
        flag = 1'b0;
        repeat (15) begin
            @(negedge clk);
            flag |= rsp_valid[0] | busy[0];
        end
        chk("no_rsp_after_rst", 16'(flag), 16'd0);

        txn(1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        txn(1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            txn(1, 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
